// File: rtl/osc_freq_meter_if.sv
// Control and result bundle between an oscillator-check consumer and osc_freq_meter.
// The master issues start/continuous and limits; the slave (meter) returns status and results.
interface osc_freq_meter_if #(
  parameter int CW = 16
);
  logic          start;
  logic          continuous;
  logic [CW-1:0] lo_limit;
  logic [CW-1:0] hi_limit;
  logic          busy;
  logic [CW-1:0] count;
  logic          valid;
  logic          overflow;
  logic          in_range;

  modport master (
    output start, continuous, lo_limit, hi_limit,
    input  busy, count, valid, overflow, in_range
  );

  modport slave (
    input  start, continuous, lo_limit, hi_limit,
    output busy, count, valid, overflow, in_range
  );
endinterface

// File: rtl/osc_freq_meter.sv
// Counts rising edges of an async slow signal over GATE_CYCLES clk cycles, reports count/overflow/in_range.
// Latency: result valid GATE_CYCLES+1 cycles after start; no backpressure, results hold until the next valid.
module osc_freq_meter #(
  parameter int GATE_CYCLES = 27000,
  parameter int CW          = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sig_in,
  osc_freq_meter_if.slave mif
);
  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GATE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          s1, s2, s3;
  logic          sig_edge;
  logic [GW-1:0] gate_cnt;
  logic [CW-1:0] edge_cnt;
  logic          ovf;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          overflow_q;
  logic          in_range_q;

  // s1/s2 form the synchronizer; s3 only delays s2 for edge detection
  assign sig_edge     = s2 & ~s3;
  assign mif.busy     = (state != IDLE);
  assign mif.count    = count_q;
  assign mif.valid    = valid_q;
  assign mif.overflow = overflow_q;
  assign mif.in_range = in_range_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      s1      <= sig_in;
      s2      <= s1;
      s3      <= s2;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mif.start || mif.continuous) begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + GW'(1);
          if (sig_edge) begin
            if (&edge_cnt) ovf <= 1'b1;
            else           edge_cnt <= edge_cnt + CW'(1);
          end
          if (gate_cnt == GATE_LAST) state <= DONE;
        end
        DONE: begin
          // Edges seen in this cycle are deliberately dropped: one dead cycle per window
          count_q    <= edge_cnt;
          overflow_q <= ovf;
          in_range_q <= (mif.lo_limit <= edge_cnt) && (edge_cnt <= mif.hi_limit);
          valid_q    <= 1'b1;
          if (mif.continuous) begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
